// File: rtl/punc_mem_pkg.sv
// Shared definitions for the PUnC memory responder: state encoding,
// default IO address, latency limit and the address-range helper.
package punc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_IO_ADDR  = 16'hFFFE;
    localparam int          MAX_READ_LATENCY = 7;

    // True when the word address falls inside a 2**aw deep array.
    function automatic logic addr_in_range(input logic [15:0] addr, input int aw);
        if (aw >= 16) begin
            return 1'b1;
        end
        return ((addr >> aw) == 16'd0);
    endfunction

endpackage

// File: rtl/punc_mem_array.sv
// Word storage: synchronous write with enable, asynchronous read.
// Contents are deliberately not reset.
module punc_mem_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Commit a write on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/punc_mem_responder.sv
// Memory-side responder for the PUnC processor: one request at a time,
// writes commit on acceptance, responses are a one-cycle pulse after a
// fixed latency (1 cycle for writes, READ_LATENCY cycles for reads).
module punc_mem_responder
    import punc_mem_pkg::*;
#(
    parameter int          DATA_WIDTH   = 16,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] IO_ADDR      = DEFAULT_IO_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [15:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] io_out,
    output logic                  io_strobe
);

    // Latency outside 1..7 is clamped so the 3-bit counter never wraps.
    localparam int RL_EFF = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                            (READ_LATENCY < 1) ? 1 : READ_LATENCY;
    localparam logic [2:0] CNT_LOAD = (RL_EFF >= 2) ? 3'(RL_EFF - 2) : 3'd0;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_next;
    logic                  r_we;
    logic [15:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_io_out;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    logic w_accept;
    logic w_req_in_range;
    logic w_req_is_io;
    logic w_arr_we;
    logic w_lat_in_range;
    logic w_lat_is_io;

    assign req_ready      = (r_state != ST_WAIT);
    assign w_accept       = req_valid && req_ready;
    assign w_req_in_range = addr_in_range(req_addr, ADDR_WIDTH);
    assign w_req_is_io    = (req_addr == IO_ADDR) && !w_req_in_range;
    // Gating with rst_n keeps a write from sneaking in while reset is held.
    assign w_arr_we       = w_accept && req_we && w_req_in_range && rst_n;

    assign w_lat_in_range = addr_in_range(r_addr, ADDR_WIDTH);
    assign w_lat_is_io    = (r_addr == IO_ADDR) && !w_lat_in_range;

    punc_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (req_addr[ADDR_WIDTH-1:0]),
        .i_wdata (req_wdata),
        .i_raddr (r_addr[ADDR_WIDTH-1:0]),
        .o_rdata (w_arr_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; RESP accepts a new request exactly like IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (req_we || RL_EFF == 1) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    // Request latch: remembers the accepted operation for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= 16'd0;
        end else if (w_accept) begin
            r_we   <= req_we;
            r_addr <= req_addr;
        end
    end

    // Memory-mapped output register, updated on the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_io_out <= '0;
        end else if (w_accept && req_we && w_req_is_io) begin
            r_io_out <= req_wdata;
        end
    end

    // Response outputs are decoded purely from registered state.
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && !w_lat_in_range && !w_lat_is_io;
    assign io_strobe = rsp_valid && r_we && w_lat_is_io;
    assign io_out    = r_io_out;

    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid && !r_we) begin
            if (w_lat_in_range) begin
                rsp_rdata = w_arr_rdata;
            end else if (w_lat_is_io) begin
                rsp_rdata = r_io_out;
            end
        end
    end

endmodule

// File: tb/tb_punc_mem_responder.sv
// Self-checking bench: two responders (latency 3 and latency 1) driven by
// directed and random transactions, checked against a word-level model.
module tb_punc_mem_responder;

    localparam int          RL_A = 3;
    localparam int          RL_B = 1;
    localparam logic [15:0] IOA  = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        val_a = 1'b0, val_b = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0, wdata = '0;

    logic        rdy_a, rv_a, err_a, strb_a;
    logic        rdy_b, rv_b, err_b, strb_b;
    logic [15:0] rd_a, io_a, rd_b, io_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_m [2][256];
    logic [15:0] io_m  [2];

    always #5 clk = ~clk;

    punc_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(RL_A), .IO_ADDR(IOA)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(val_a), .req_ready(rdy_a), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a),
        .rsp_err(err_a), .io_out(io_a), .io_strobe(strb_a));

    punc_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(RL_B), .IO_ADDR(IOA)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(val_b), .req_ready(rdy_b), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b),
        .rsp_err(err_b), .io_out(io_b), .io_strobe(strb_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic o_rdy(input int s);  return (s != 0) ? rdy_b  : rdy_a;  endfunction
    function automatic logic o_rv(input int s);   return (s != 0) ? rv_b   : rv_a;   endfunction
    function automatic logic o_err(input int s);  return (s != 0) ? err_b  : err_a;  endfunction
    function automatic logic o_strb(input int s); return (s != 0) ? strb_b : strb_a; endfunction
    function automatic logic [15:0] o_rd(input int s); return (s != 0) ? rd_b : rd_a; endfunction
    function automatic logic [15:0] o_io(input int s); return (s != 0) ? io_b : io_a; endfunction

    // One complete request/response; called and returns at a negedge.
    task automatic txn(input int s, input logic w, input logic [15:0] a, input logic [15:0] d);
        int          lat;
        int          exp_lat;
        logic        in_rng, is_io, exp_err, exp_strb;
        logic [15:0] exp_rd;
        in_rng   = (a < 16'd256);
        is_io    = (a == IOA);
        exp_err  = !in_rng && !is_io;
        exp_strb = w && is_io;
        exp_lat  = w ? 1 : ((s != 0) ? RL_B : RL_A);
        exp_rd   = '0;
        if (w) begin
            if (in_rng) mem_m[s][a[7:0]] = d;
            else if (is_io) io_m[s] = d;
        end else begin
            if (in_rng) exp_rd = mem_m[s][a[7:0]];
            else if (is_io) exp_rd = io_m[s];
        end
        chk("ready_before", {31'd0, o_rdy(s)}, 32'd1);
        we = w; addr = a; wdata = d;
        if (s != 0) val_b = 1'b1; else val_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        val_a = 1'b0; val_b = 1'b0; we = 1'b0;
        lat = 1;
        while (!o_rv(s) && lat < 20) begin
            chk("ready_wait", {31'd0, o_rdy(s)}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency",    lat, exp_lat);
        chk("rdata",      {16'd0, o_rd(s)}, {16'd0, exp_rd});
        chk("err",        {31'd0, o_err(s)}, {31'd0, exp_err});
        chk("strobe",     {31'd0, o_strb(s)}, {31'd0, exp_strb});
        chk("io_out",     {16'd0, o_io(s)}, {16'd0, io_m[s]});
        chk("ready_resp", {31'd0, o_rdy(s)}, 32'd1);
        $display("txn dut=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 s, w, a, d, o_rd(s), o_err(s), lat);
        @(negedge clk);
        chk("pulse_end",  {31'd0, o_rv(s)}, 32'd0);
        chk("strobe_end", {31'd0, o_strb(s)}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        int          r;
        int          s;
        logic        w;
        logic [15:0] a;
        io_m[0] = '0; io_m[1] = '0;

        // Reset values on both instances
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready",  {31'd0, o_rdy(i)},  32'd1);
            chk("rst_valid",  {31'd0, o_rv(i)},   32'd0);
            chk("rst_rdata",  {16'd0, o_rd(i)},   32'd0);
            chk("rst_err",    {31'd0, o_err(i)},  32'd0);
            chk("rst_io",     {16'd0, o_io(i)},   32'd0);
            chk("rst_strobe", {31'd0, o_strb(i)}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Known contents for the low words of both arrays
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++)
                txn(i, 1'b1, 16'(j), 16'($urandom));

        // Directed cases
        txn(0, 1'b1, 16'h0005, 16'h1234);
        txn(0, 1'b0, 16'h0005, 16'h0000);
        txn(0, 1'b1, IOA,      16'h00AB);
        txn(0, 1'b0, IOA,      16'h0000);
        txn(0, 1'b0, 16'h0100, 16'h0000);
        txn(0, 1'b1, 16'h0100, 16'hBEEF);
        txn(0, 1'b0, 16'h0000, 16'h0000);

        // Back-to-back writes with req_valid held
        we = 1'b1; addr = 16'h0006; wdata = 16'hC0DE; val_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rsp1", {31'd0, rv_a}, 32'd1);
        addr = 16'h0007; wdata = 16'hF00D;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rsp2", {31'd0, rv_a}, 32'd1);
        chk("b2b_err2", {31'd0, err_a}, 32'd0);
        val_a = 1'b0; we = 1'b0;
        $display("txn dut=0 back-to-back writes 0006=c0de 0007=f00d");
        mem_m[0][6] = 16'hC0DE;
        mem_m[0][7] = 16'hF00D;
        @(negedge clk);
        chk("b2b_idle", {31'd0, rv_a}, 32'd0);
        txn(0, 1'b0, 16'h0006, 16'h0000);
        txn(0, 1'b0, 16'h0007, 16'h0000);

        // Latency-1 instance
        txn(1, 1'b1, 16'h0009, 16'h5A5A);
        txn(1, 1'b0, 16'h0009, 16'h0000);
        txn(1, 1'b1, IOA,      16'h0042);

        // Reset during the WAIT phase of a read
        we = 1'b0; addr = 16'h0005; val_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        val_a = 1'b0;
        chk("wait_ready", {31'd0, rdy_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        io_m[0] = '0; io_m[1] = '0;
        chk("mid_rst_valid", {31'd0, rv_a},  32'd0);
        chk("mid_rst_ready", {31'd0, rdy_a}, 32'd1);
        chk("mid_rst_io_a",  {16'd0, io_a},  32'd0);
        chk("mid_rst_io_b",  {16'd0, io_b},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rv_a) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("ready_after_rst",  {31'd0, rdy_a}, 32'd1);
        $display("txn dut=0 read 0005 aborted by reset");
        txn(0, 1'b0, 16'h0005, 16'h0000);
        txn(1, 1'b0, 16'h0009, 16'h0000);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            s = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 16'($urandom_range(0, 15));
            else if (r < 8)  a = IOA;
            else             a = 16'($urandom_range(256, 65533));
            txn(s, w, a, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/punc_mem_responder.md
# punc_mem_responder

- Memory-side responder for the PUnC multicycle processor; serves the opposite end of the load/store and instruction-fetch requests issued by the processor control FSM.
- Accepts one request at a time on a valid/ready request channel.
- Writes commit to an internal word array, or to a memory-mapped output register.
- Returns each response as a single-cycle `rsp_valid` pulse after a fixed, parameterised latency, so the processor can be exercised against slow memory.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width.
- `ADDR_WIDTH`, 8, array index width; depth = 2**ADDR_WIDTH words.
- `READ_LATENCY`, 2, cycles from read acceptance to `rsp_valid`; legal range 1..7.
- `IO_ADDR`, 16'hFFFE, address of the memory-mapped output register.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 16: word address.
- `req_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: one-cycle response pulse; there is no backpressure.
- `rsp_rdata` out DATA_WIDTH: read data, valid only while `rsp_valid`; 0 for write responses.
- `rsp_err` out 1: address unmapped, valid only while `rsp_valid`.
- `io_out` out DATA_WIDTH: memory-mapped output register.
- `io_strobe` out 1: one-cycle pulse when `io_out` is written.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: latency countdown, `req_ready`=0.
  - RESP: `rsp_valid`=1, `req_ready`=1.
- Acceptance happens on any rising edge where `req_valid && req_ready`. On acceptance the block latches `we`, `addr` and `wdata`.
- Address decode:
  - In-range: `addr < 2**ADDR_WIDTH`.
  - IO: `addr == IO_ADDR`.
  - Anything else is unmapped.
- Writes commit on the acceptance edge itself:
  - In-range: the array word is updated.
  - IO: `io_out` is updated.
  - Unmapped: the write is dropped.
- Write response: RESP in the cycle after acceptance. `rsp_err`=1 only if the address is unmapped.
- Read response:
  - READ_LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT with a 3-bit counter loaded with READ_LATENCY-2; decrement to 0, then go to RESP.
  - `rsp_rdata`:
    - In-range: array word.
    - IO: `io_out`.
    - Unmapped: 0 with `rsp_err`=1.
- RESP transitions:
  - To IDLE if no new request is accepted.
  - If a new request is accepted in the RESP cycle, handle it exactly as an acceptance from IDLE (back-to-back).
- `io_strobe` is high in the same cycle as the `rsp_valid` of an IO write.
- Array contents are not reset. A write followed by a read to the same address returns the new data.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `io_out`=0, `io_strobe`=0, counter 0.
- Read accepted at edge k: `rsp_valid` is high during the cycle after edge k+READ_LATENCY-1, i.e. READ_LATENCY cycles after acceptance.
- Write accepted at edge k: `rsp_valid` is high during the cycle after edge k.
- Maximum throughput: one write per cycle (back-to-back through RESP); one read per READ_LATENCY cycles.
- `req_*` inputs are ignored while `req_ready`=0.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - The pending response is lost.
  - A write already accepted stays committed.
  - `io_out` clears to 0.
- All outputs are registered or decoded from the state register. There is no combinational path from `req_*` to `rsp_*`.

## Structure
- Shared package `punc_mem_pkg`:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Default IO_ADDR.
  - Max latency constant (7).
- Sub-module `punc_mem_array`: DATA_WIDTH x 2**ADDR_WIDTH storage, synchronous write with enable, asynchronous read.
- Top level holds the FSM, the latency counter, the request latch, address decode and the IO register.

## Test plan
- Reset → all outputs 0, `req_ready`=1. Write 16'h1234 to addr 8'h05 → `rsp_valid` 1 cycle later, `rsp_err`=0.
- READ_LATENCY=3, read addr 8'h05 after the write → `rsp_valid` exactly 3 cycles after acceptance, `rsp_rdata`=16'h1234, `req_ready`=0 in the two intervening cycles.
- Write 16'h00AB to IO_ADDR → `io_out`=16'h00AB and `io_strobe` pulse coincident with `rsp_valid`; a following read of IO_ADDR returns 16'h00AB.
- Read addr 16'h0100 (unmapped, ADDR_WIDTH=8) → `rsp_rdata`=0, `rsp_err`=1. Write to 16'h0100 → `rsp_err`=1 and no array change (verify by reading 8'h00).
- Two writes presented back-to-back with `req_valid` held → two consecutive `rsp_valid` pulses and both words stored. READ_LATENCY=1 read → response next cycle.
- Assert `rst_n` low during WAIT of a read → no `rsp_valid` ever for that read, `io_out`=0, `req_ready`=1 after release. Previously written data is still readable.
